// File: rtl/soc_timer_pkg.sv
// Shared register offsets, CTRL bit positions and reset constants for the machine timer.
package soc_timer_pkg;

  localparam logic [7:0] TIMER_CTRL  = 8'h00;
  localparam logic [7:0] TIMER_COUNT = 8'h04;
  localparam logic [7:0] TIMER_VALUE = 8'h08;

  localparam int unsigned CTRL_EN        = 0;
  localparam int unsigned CTRL_IE        = 1;
  localparam int unsigned CTRL_PEND      = 2;
  localparam int unsigned CTRL_PRESC_LSB = 8;

  localparam logic [31:0] VALUE_RST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    SelNone,
    SelCtrl,
    SelCount,
    SelValue
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [7:0] offset);
    reg_sel_e sel;
    case (offset)
      TIMER_CTRL:  sel = SelCtrl;
      TIMER_COUNT: sel = SelCount;
      TIMER_VALUE: sel = SelValue;
      default:     sel = SelNone;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: emits one tick every (presc+1) enabled cycles.
module timer_prescaler #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic               restart,
  output logic               tick
);

  logic [PRESC_W-1:0] pcnt_q;

  assign tick = en && (pcnt_q == presc);

  always_ff @(posedge clk) begin
    if (rst || !en || restart || tick) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/soc_timer.sv
// Memory-mapped machine timer: prescaled 32-bit counter, compare value and sticky pending flag.
module soc_timer
  import soc_timer_pkg::*;
#(
  parameter int unsigned PRESC_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        int_sig_o
);

  logic               en_q;
  logic               ie_q;
  logic               pend_q;
  logic [PRESC_W-1:0] presc_q;
  logic [31:0]        count_q;
  logic [31:0]        value_q;

  reg_sel_e           sel;
  logic               wr_ctrl;
  logic               wr_count;
  logic               wr_value;
  logic               presc_chg;
  logic               tick;
  logic               match;
  logic               unused_addr;

  assign sel         = decode_addr(addr_i[7:0]);
  assign unused_addr = ^addr_i[31:8];

  assign wr_ctrl   = we_i && (sel == SelCtrl);
  assign wr_count  = we_i && (sel == SelCount);
  assign wr_value  = we_i && (sel == SelValue);
  assign presc_chg = wr_ctrl && (data_i[CTRL_PRESC_LSB +: PRESC_W] != presc_q);

  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (en_q),
    .presc   (presc_q),
    .restart (presc_chg),
    .tick    (tick)
  );

  // A software COUNT write in a tick cycle overrides the tick, so no compare is evaluated.
  assign match = tick && !wr_count && (count_q >= value_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= 1'b0;
      ie_q    <= 1'b0;
      pend_q  <= 1'b0;
      presc_q <= '0;
      count_q <= '0;
      value_q <= VALUE_RST;
    end else begin
      if (wr_ctrl) begin
        en_q    <= data_i[CTRL_EN];
        ie_q    <= data_i[CTRL_IE];
        presc_q <= data_i[CTRL_PRESC_LSB +: PRESC_W];
      end
      // Hardware set beats a same-cycle W1C so no event is lost.
      if (match) begin
        pend_q <= 1'b1;
      end else if (wr_ctrl && data_i[CTRL_PEND]) begin
        pend_q <= 1'b0;
      end
      if (wr_count) begin
        count_q <= data_i;
      end else if (match) begin
        count_q <= '0;
      end else if (tick) begin
        count_q <= count_q + 32'd1;
      end
      if (wr_value) begin
        value_q <= data_i;
      end
    end
  end

  always_comb begin
    data_o = '0;
    case (sel)
      SelCtrl: begin
        data_o[CTRL_EN]                      = en_q;
        data_o[CTRL_IE]                      = ie_q;
        data_o[CTRL_PEND]                    = pend_q;
        data_o[CTRL_PRESC_LSB +: PRESC_W]    = presc_q;
      end
      SelCount: data_o = count_q;
      SelValue: data_o = value_q;
      default:  data_o = '0;
    endcase
  end

  assign int_sig_o = pend_q & ie_q;

endmodule

// File: doc/soc_timer.md
# soc_timer

Memory-mapped machine timer peripheral that generates the timer interrupt request consumed by the core's interrupt controller (drives the timer bit of the core's `int_flag_i` bus, the source of cause `0x80000004`). It holds a programmable prescaler, a 32-bit up-counter and a compare value, and raises a sticky pending flag on compare match. Software configures and acknowledges it through the peripheral bus via load/store instructions.

## Interface
Parameters:
- `PRESC_W`, default 8: width of the prescaler divide field.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `we_i`  in  1  bus write strobe; write takes effect at the next rising edge.
- `addr_i`  in  32  byte address; only `addr_i[7:0]` is decoded.
- `data_i`  in  32  write data.
- `data_o`  out  32  read data, combinational from `addr_i`.
- `int_sig_o`  out  1  timer interrupt request, level, to the core interrupt input.

## Operation
- Register map:
  - `0x00 CTRL`
    - bit0 `EN`: count enable.
    - bit1 `IE`: interrupt enable.
    - bit2 `PEND`: read-only status; writing 1 clears it (W1C).
    - bits[8+PRESC_W-1:8] `PRESC`.
    - All other bits read 0.
  - `0x04 COUNT`: read/write.
  - `0x08 VALUE`: compare value, read/write.
  - Other offsets read 0; writes to them are ignored.
- Prescaler:
  - When `EN`=1, the internal `pcnt` counts 0..`PRESC`.
  - A tick is generated in the cycle `pcnt`==`PRESC`, and `pcnt` wraps to 0 in that cycle.
  - `PRESC`=0 gives one tick per cycle.
  - `EN`=0 holds `pcnt` at 0 and suppresses ticks.
- Counter, on each tick:
  - If `COUNT` >= `VALUE`: `COUNT` <= 0 and `PEND` <= 1.
  - Otherwise: `COUNT` <= `COUNT`+1.
  - The comparison is unsigned, 32-bit. `VALUE`=0 sets `PEND` on every tick with `COUNT` held at 0.
- `int_sig_o` = `PEND` & `IE`. It is combinational from registers, so there is no glitch source.
- Simultaneous events:
  - Hardware set of `PEND` and a W1C in the same cycle: the set wins, so no event is lost.
  - Software write to `COUNT` in a tick cycle: the software value wins, and no match is evaluated that cycle.
  - Write to `CTRL` with `PRESC` changed: `pcnt` restarts at 0.
  - Write to `VALUE`: takes effect for the next tick comparison; `COUNT` is not altered.
- Reset mid-count: all state returns to reset values on the next edge. Any pending interrupt is dropped.

## Timing
- Reset values:
  - `CTRL`=0, `COUNT`=0, `VALUE`=0xFFFF_FFFF, `pcnt`=0.
  - Outputs: `data_o` shows 0 unless a mapped address is presented; `int_sig_o`=0.
- Reads: zero latency; `data_o` follows `addr_i` in the same cycle.
- Writes: visible on `data_o` the cycle after the edge that samples `we_i`.
- Match-to-interrupt latency:
  - `PEND` rises at the edge of the matching tick.
  - `int_sig_o` rises in the same cycle as `PEND` when `IE`=1.
- Period: with `EN` set and `COUNT` starting at 0, `PEND` sets after (`VALUE`+1)×(`PRESC`+1) cycles.
- Acknowledge: the W1C at edge N drops `int_sig_o` after edge N. The interrupt controller then sees `int_flag_i` clear before `mret`.

## Structure
- Shared defines header (alongside the existing ones) holds:
  - `TIMER_CTRL`/`TIMER_COUNT`/`TIMER_VALUE` offsets.
  - `CTRL` bit positions.
  - `VALUE` reset constant.
- Sub-module `timer_prescaler`:
  - Inputs: `clk`, `rst`, `en`, `presc`, `restart`.
  - Output: `tick`.
  - Contains the `pcnt` counter and wrap logic.
- Top level holds the register file, address decode, compare logic and W1C logic.

## Test plan
- Reset, then read `0x00`/`0x04`/`0x08`/`0x0C` -> 0, 0, 0xFFFF_FFFF, 0; `int_sig_o`=0.
- `VALUE`=4, `PRESC`=0, `CTRL`=0x3 -> `COUNT` sequence 1,2,3,4,0; `int_sig_o` rises exactly 5 cycles after the `CTRL` write takes effect.
- `VALUE`=2, `PRESC`=3, `IE`=0 -> `PEND` (`CTRL` bit2) sets after 12 cycles; `int_sig_o` stays 0; later set `IE` -> `int_sig_o`=1 the next cycle.
- Pending interrupt, write `CTRL`=0x7 (W1C) -> `int_sig_o` 0 the next cycle; W1C coinciding with a match tick -> `PEND` remains 1.
- Write `COUNT`=0x10 during a tick cycle with `VALUE`=0x20 -> `COUNT` reads 0x10, then increments to 0x11 on the following tick.
- Assert `rst` one cycle while `COUNT`=7 and `PEND`=1 -> all registers at reset values and `int_sig_o`=0 the next cycle.
